// File: rtl/seq_mul_radix_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : seq_mul_radix_pkg                                       |
// | Brief   : State encoding and latency helper for seq_mul_radix.    |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
package seq_mul_radix_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of BUSY cycles needed to retire every multiplier bit.
    function automatic int mul_latency(input int width, input int bpc);
        return width / bpc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mul_radix_digit_sel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : mul_digit_sel                                           |
// | Brief   : Selects the partial product {0, A, 2A, 3A} for a 2-bit  |
// |           multiplier digit.                                       |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module mul_digit_sel #(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       digit_i,
    input  logic [WIDTH-1:0] a_i,
    output logic [WIDTH+1:0] pp_o
);

    // Partial product mux; 3A is formed as A + 2A at WIDTH+2 bits so it never wraps.
    always_comb begin
        pp_o = '0;
        case (digit_i)
            2'd0:    pp_o = '0;
            2'd1:    pp_o = {2'b00, a_i};
            2'd2:    pp_o = {1'b0, a_i, 1'b0};
            2'd3:    pp_o = {2'b00, a_i} + {1'b0, a_i, 1'b0};
            default: pp_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_mul_radix.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : seq_mul_radix                                           |
// | Brief   : Iterative shift-add unsigned multiplier retiring 1 or 2 |
// |           multiplier bits per cycle, with start/done handshake.   |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module seq_mul_radix
    import seq_mul_radix_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iStart,
    input  logic [WIDTH-1:0]     iA,
    input  logic [WIDTH-1:0]     iB,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [2*WIDTH-1:0]   oResult
);

    localparam int N   = mul_latency(WIDTH, BITS_PER_CYCLE);
    localparam int CW  = $clog2(N + 1);
    localparam int ACC = 2 * WIDTH + 2;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [ACC-1:0]       acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   res_q, res_d;

    logic [1:0]           digit;
    logic [WIDTH+1:0]     pp;
    logic [ACC-1:0]       acc_sum;

    // Current digit comes from the bottom of the multiplier shift register.
    generate
        if (BITS_PER_CYCLE == 1) begin : g_radix2
            assign digit = {1'b0, b_q[0]};
        end else begin : g_radix4
            assign digit = b_q[1:0];
        end
    endgenerate

    mul_digit_sel #(
        .WIDTH (WIDTH)
    ) u_digit_sel (
        .digit_i (digit),
        .a_i     (a_q),
        .pp_o    (pp)
    );

    // Partial product enters at the top of the accumulator, then everything shifts down.
    assign acc_sum = acc_q + {pp, {WIDTH{1'b0}}};

    // State and datapath registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Next-state and datapath update; the product is captured on the last BUSY edge.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (iStart) begin
                    a_d     = iA;
                    b_d     = iB;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_sum >> BITS_PER_CYCLE;
                b_d   = b_q >> BITS_PER_CYCLE;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    res_d   = acc_d[2*WIDTH-1:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign oBusy   = (state_q == BUSY);
    assign oDone   = (state_q == DONE);
    assign oResult = res_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul_radix.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_seq_mul_radix                                        |
// | Brief   : Self-checking bench for seq_mul_radix with scoreboards  |
// |           on four parameter sets (16/2, 8/1, 8/2, 32/2).          |
// | Revision: 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module tb_seq_mul_radix;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // 16-bit radix-4 instance (main directed target)
    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] res16;
    logic [31:0] q16[$];

    // 8-bit radix-2 instance
    logic        start8a = 1'b0;
    logic [7:0]  a8a = '0, b8a = '0;
    logic        busy8a, done8a;
    logic [15:0] res8a;
    logic [15:0] q8a[$];

    // 8-bit radix-4 instance
    logic        start8b = 1'b0;
    logic [7:0]  a8b = '0, b8b = '0;
    logic        busy8b, done8b;
    logic [15:0] res8b;
    logic [15:0] q8b[$];

    // 32-bit radix-4 instance
    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [63:0] res32;
    logic [63:0] q32[$];

    seq_mul_radix #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut16 (
        .Clock(clk), .Reset(rst), .iStart(start16), .iA(a16), .iB(b16),
        .oBusy(busy16), .oDone(done16), .oResult(res16));
    seq_mul_radix #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8a (
        .Clock(clk), .Reset(rst), .iStart(start8a), .iA(a8a), .iB(b8a),
        .oBusy(busy8a), .oDone(done8a), .oResult(res8a));
    seq_mul_radix #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut8b (
        .Clock(clk), .Reset(rst), .iStart(start8b), .iA(a8b), .iB(b8b),
        .oBusy(busy8b), .oDone(done8b), .oResult(res8b));
    seq_mul_radix #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut32 (
        .Clock(clk), .Reset(rst), .iStart(start32), .iA(a32), .iB(b32),
        .oBusy(busy32), .oDone(done32), .oResult(res32));

    // Reset level seen by the most recent posedge (inputs change only at posedge+1).
    logic prev_rst = 1'b1;
    always @(negedge clk) prev_rst <= rst;

    // Scoreboard monitors: product on done, single-cycle done, result stable otherwise.
    logic        pd16 = 1'b0;
    logic [31:0] pr16;
    always @(negedge clk) begin
        if (done16) begin
            n_checks++;
            if (q16.size() == 0) begin
                n_errors++; $display("FAIL sb16_unexpected_done got=%0h required=none", res16);
            end else begin
                logic [31:0] e;
                e = q16.pop_front();
                if (res16 !== e) begin n_errors++; $display("FAIL sb16_result got=%0h required=%0h", res16, e); end
            end
            n_checks++;
            if (pd16) begin n_errors++; $display("FAIL sb16_done_width got=2+ cycles required=1"); end
        end else if (!prev_rst) begin
            n_checks++;
            if (res16 !== pr16) begin n_errors++; $display("FAIL sb16_stable got=%0h required=%0h", res16, pr16); end
        end
        pd16 = done16; pr16 = res16;
    end

    logic        pd8a = 1'b0;
    logic [15:0] pr8a;
    always @(negedge clk) begin
        if (done8a) begin
            n_checks++;
            if (q8a.size() == 0) begin
                n_errors++; $display("FAIL sb8a_unexpected_done got=%0h required=none", res8a);
            end else begin
                logic [15:0] e;
                e = q8a.pop_front();
                if (res8a !== e) begin n_errors++; $display("FAIL sb8a_result got=%0h required=%0h", res8a, e); end
            end
            n_checks++;
            if (pd8a) begin n_errors++; $display("FAIL sb8a_done_width got=2+ cycles required=1"); end
        end else if (!prev_rst) begin
            n_checks++;
            if (res8a !== pr8a) begin n_errors++; $display("FAIL sb8a_stable got=%0h required=%0h", res8a, pr8a); end
        end
        pd8a = done8a; pr8a = res8a;
    end

    logic        pd8b = 1'b0;
    logic [15:0] pr8b;
    always @(negedge clk) begin
        if (done8b) begin
            n_checks++;
            if (q8b.size() == 0) begin
                n_errors++; $display("FAIL sb8b_unexpected_done got=%0h required=none", res8b);
            end else begin
                logic [15:0] e;
                e = q8b.pop_front();
                if (res8b !== e) begin n_errors++; $display("FAIL sb8b_result got=%0h required=%0h", res8b, e); end
            end
            n_checks++;
            if (pd8b) begin n_errors++; $display("FAIL sb8b_done_width got=2+ cycles required=1"); end
        end else if (!prev_rst) begin
            n_checks++;
            if (res8b !== pr8b) begin n_errors++; $display("FAIL sb8b_stable got=%0h required=%0h", res8b, pr8b); end
        end
        pd8b = done8b; pr8b = res8b;
    end

    logic        pd32 = 1'b0;
    logic [63:0] pr32;
    always @(negedge clk) begin
        if (done32) begin
            n_checks++;
            if (q32.size() == 0) begin
                n_errors++; $display("FAIL sb32_unexpected_done got=%0h required=none", res32);
            end else begin
                logic [63:0] e;
                e = q32.pop_front();
                if (res32 !== e) begin n_errors++; $display("FAIL sb32_result got=%0h required=%0h", res32, e); end
            end
            n_checks++;
            if (pd32) begin n_errors++; $display("FAIL sb32_done_width got=2+ cycles required=1"); end
        end else if (!prev_rst) begin
            n_checks++;
            if (res32 !== pr32) begin n_errors++; $display("FAIL sb32_stable got=%0h required=%0h", res32, pr32); end
        end
        pd32 = done32; pr32 = res32;
    end

    // One 16-bit operation: lat = edges from the accept edge to done, nbusy = busy cycles seen.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, output int lat, output int nbusy);
        @(posedge clk); #1;
        start16 = 1'b1; a16 = a; b16 = b;
        q16.push_back(32'(a) * 32'(b));
        @(posedge clk); #1;
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        lat = 0; nbusy = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done16) break;
            if (busy16) nbusy++;
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy16 !== 1'b0)  begin n_errors++; $display("FAIL reset_busy got=%b required=0", busy16); end
        n_checks++; if (done16 !== 1'b0)  begin n_errors++; $display("FAIL reset_done got=%b required=0", done16); end
        n_checks++; if (res16 !== 32'd0)  begin n_errors++; $display("FAIL reset_result got=%0h required=0", res16); end
        n_checks++; if (res32 !== 64'd0)  begin n_errors++; $display("FAIL reset_result32 got=%0h required=0", res32); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat, nb;
        run16(16'd300, 16'd7, lat, nb);
        n_checks++; if (lat != 8) begin n_errors++; $display("FAIL basic_latency got=%0d required=8", lat); end
        n_checks++; if (nb != 8)  begin n_errors++; $display("FAIL basic_busy_cycles got=%0d required=8", nb); end
    endtask

    task automatic test_corners;
        int lat, nb;
        run16(16'hFFFF, 16'hFFFF, lat, nb);
        n_checks++; if (lat != 8) begin n_errors++; $display("FAIL max_latency got=%0d required=8", lat); end
        run16(16'h0000, 16'h1234, lat, nb);
        n_checks++; if (lat != 8) begin n_errors++; $display("FAIL zeroA_latency got=%0d required=8", lat); end
        run16(16'h1234, 16'h0000, lat, nb);
        n_checks++; if (lat != 8) begin n_errors++; $display("FAIL zeroB_latency got=%0d required=8", lat); end
    endtask

    // Same operands through radix-2 and radix-4 8-bit instances side by side.
    task automatic test_radix;
        int lat_a, lat_b, cyc;
        lat_a = -1; lat_b = -1;
        @(posedge clk); #1;
        start8a = 1'b1; a8a = 8'd13; b8a = 8'd11; q8a.push_back(16'd143);
        start8b = 1'b1; a8b = 8'd13; b8b = 8'd11; q8b.push_back(16'd143);
        @(posedge clk); #1;
        start8a = 1'b0; start8b = 1'b0; a8a = 8'd0; a8b = 8'd0;
        cyc = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done8a && lat_a < 0) lat_a = cyc;
            if (done8b && lat_b < 0) lat_b = cyc;
            @(posedge clk);
            cyc++;
        end
        n_checks++; if (lat_a != 8) begin n_errors++; $display("FAIL radix2_latency got=%0d required=8", lat_a); end
        n_checks++; if (lat_b != 4) begin n_errors++; $display("FAIL radix4_latency got=%0d required=4", lat_b); end
    endtask

    task automatic test_ignore_start;
        int k;
        @(posedge clk); #1;
        start16 = 1'b1; a16 = 16'd3; b16 = 16'd4; q16.push_back(32'd12);
        @(posedge clk); #1;
        start16 = 1'b0;
        @(posedge clk); #1;
        start16 = 1'b1; a16 = 16'd5; b16 = 16'd5;
        @(posedge clk); #1;
        start16 = 1'b0;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done16) break;
        end
        n_checks++; if (k == 40) begin n_errors++; $display("FAIL ignore_timeout got=no done required=done"); end
        @(negedge clk);
        n_checks++; if (busy16 !== 1'b0) begin n_errors++; $display("FAIL ignore_restart got=%b required=0", busy16); end
        repeat (12) @(negedge clk);
        n_checks++; if (q16.size() != 0) begin n_errors++; $display("FAIL ignore_queue got=%0d required=0", q16.size()); end
    endtask

    // Start held high: a new operation begins on every IDLE visit, N+2 cycles apart.
    task automatic test_back_to_back;
        int ndone, last, cyc;
        ndone = 0; last = -1; cyc = 0;
        repeat (3) q16.push_back(32'd42);
        @(posedge clk); #1;
        start16 = 1'b1; a16 = 16'd6; b16 = 16'd7;
        for (int k = 0; k < 60 && ndone < 3; k++) begin
            @(negedge clk);
            if (done16) begin
                if (last >= 0) begin
                    n_checks++;
                    if (cyc - last != 10) begin n_errors++; $display("FAIL b2b_period got=%0d required=10", cyc - last); end
                end
                last = cyc;
                ndone++;
                if (ndone == 3) start16 = 1'b0;
            end
            cyc++;
        end
        start16 = 1'b0;
        n_checks++; if (ndone != 3) begin n_errors++; $display("FAIL b2b_count got=%0d required=3", ndone); end
        repeat (3) @(negedge clk);
        n_checks++; if (busy16 !== 1'b0) begin n_errors++; $display("FAIL b2b_extra_op got=%b required=0", busy16); end
    endtask

    // Reset in the 4th BUSY cycle with start also high: reset wins and the op is dropped.
    task automatic test_reset_mid;
        int lat, nb;
        @(posedge clk); #1;
        start16 = 1'b1; a16 = 16'd3; b16 = 16'd4; q16.push_back(32'd12);
        @(posedge clk); #1;
        start16 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1; start16 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start16 = 1'b0;
        q16.delete();
        @(negedge clk);
        n_checks++; if (busy16 !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got=%b required=0", busy16); end
        n_checks++; if (done16 !== 1'b0) begin n_errors++; $display("FAIL rstmid_done got=%b required=0", done16); end
        n_checks++; if (res16 !== 32'd0) begin n_errors++; $display("FAIL rstmid_result got=%0h required=0", res16); end
        @(negedge clk);
        n_checks++; if (busy16 !== 1'b0) begin n_errors++; $display("FAIL rstmid_start_won got=%b required=0", busy16); end
        run16(16'd9, 16'd9, lat, nb);
        n_checks++; if (lat != 8) begin n_errors++; $display("FAIL rstmid_latency got=%0d required=8", lat); end
    endtask

    task automatic test_random;
        fork
            begin
                int lat, nb;
                for (int i = 0; i < 1000; i++) begin
                    run16(16'($urandom), 16'($urandom), lat, nb);
                    n_checks++;
                    if (lat != 8) begin n_errors++; $display("FAIL rand16_latency got=%0d required=8", lat); end
                end
            end
            begin
                int k;
                for (int i = 0; i < 1000; i++) begin
                    @(posedge clk); #1;
                    start8a = 1'b1; a8a = 8'($urandom); b8a = 8'($urandom);
                    q8a.push_back(16'(a8a) * 16'(b8a));
                    @(posedge clk); #1;
                    start8a = 1'b0;
                    for (k = 0; k < 40; k++) begin @(negedge clk); if (done8a) break; end
                    n_checks++;
                    if (k == 40) begin n_errors++; $display("FAIL rand8a_timeout got=no done required=done"); end
                end
            end
            begin
                int k;
                for (int i = 0; i < 1000; i++) begin
                    @(posedge clk); #1;
                    start8b = 1'b1; a8b = 8'($urandom); b8b = 8'($urandom);
                    q8b.push_back(16'(a8b) * 16'(b8b));
                    @(posedge clk); #1;
                    start8b = 1'b0;
                    for (k = 0; k < 40; k++) begin @(negedge clk); if (done8b) break; end
                    n_checks++;
                    if (k == 40) begin n_errors++; $display("FAIL rand8b_timeout got=no done required=done"); end
                end
            end
            begin
                int k;
                for (int i = 0; i < 1000; i++) begin
                    @(posedge clk); #1;
                    start32 = 1'b1;
                    a32 = (i == 0) ? 32'hFFFF_FFFF : $urandom;
                    b32 = (i == 0) ? 32'hFFFF_FFFF : $urandom;
                    q32.push_back(64'(a32) * 64'(b32));
                    @(posedge clk); #1;
                    start32 = 1'b0;
                    for (k = 0; k < 40; k++) begin @(negedge clk); if (done32) break; end
                    n_checks++;
                    if (k == 40) begin n_errors++; $display("FAIL rand32_timeout got=no done required=done"); end
                end
            end
        join
        repeat (4) @(negedge clk);
        n_checks++;
        if (q16.size() + q8a.size() + q8b.size() + q32.size() != 0) begin
            n_errors++;
            $display("FAIL rand_leftover got=%0d required=0", q16.size() + q8a.size() + q8b.size() + q32.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_radix();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
